masked_keccak_harness: RTL and testbench

Parametrised run controller for the masked Keccak core (keccak_top) at any masking order D. It splits an unmasked state into D+1 Boolean shares and launches the core through its reset/ready protocol. It collects and unmasks the result, and repeats for a requested number of runs with fresh masks, flagging any cross-run inconsistency or core timeout. It sits between a host/self-test controller and one keccak_top instance.

---
 rtl/mkh_pkg.sv | 19 +
 rtl/mkh_xor_reduce.sv | 20 ++
 rtl/masked_keccak_harness.sv | 147 ++++++++++++++
 tb/tb_masked_keccak_harness.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mkh_pkg.sv
// Shared types and helpers for the masked Keccak run controller.
// Imported by masked_keccak_harness.
package mkh_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHARE,
      LAUNCH,
      WAIT,
      UNMASK,
      DONE
   } state_t;

   // Width of a counter that must hold every value 0..timeout inclusive.
   function automatic int mkh_cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mkh_xor_reduce.sv
// XOR of N packed W-bit words; used both to build the last Boolean share
// and to recombine the core's output shares.
module mkh_xor_reduce #(
   parameter int N = 2,
   parameter int W = 8
) (
   input  logic [N*W-1:0] words,
   output logic [W-1:0]   result
);

   // NOTE: assigning a default before the loop keeps this block purely
   // combinational; a path that skips the assignment would infer a latch.
   always_comb begin
      result = '0;
      for (int i = 0; i < N; i++) begin
         result ^= words[i*W +: W];
      end
   end

endmodule

// File: rtl/masked_keccak_harness.sv
// Run controller for a masked Keccak core: shares the input, launches the
// core, unmasks the result and cross-checks repeated runs.
// Optional known-answer compare is enabled by defining MKH_KAT_CHECK_EN.
module masked_keccak_harness
   import mkh_pkg::*;
#(
   parameter int D       = 1,
   parameter int W       = 200,
   parameter int RUN_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [RUN_W-1:0]     Runs,
   input  logic [W-1:0]         InData,
   input  logic [D*W-1:0]       MaskRand,
   output logic                 Busy,
   output logic                 Done,
   output logic [W-1:0]         OutData,
   output logic                 Mismatch,
   output logic                 Timeout,
   output logic [RUN_W-1:0]     RunCount,
   output logic                 CoreReset,
   output logic [(D+1)*W-1:0]   CoreIn,
   input  logic                 CoreReady,
   input  logic [(D+1)*W-1:0]   CoreOut
`ifdef MKH_KAT_CHECK_EN
   ,
   input  logic [W-1:0]         ExpData,
   output logic                 Pass
`endif
);

   localparam int CNT_W = mkh_cnt_width(TIMEOUT);

   state_t                state, state_next;
   logic [W-1:0]          in_q;
   logic [W-1:0]          result_q;
   logic [RUN_W-1:0]      runs_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  ready_q;
   logic                  ready_edge;
   logic                  cnt_expired;
   logic                  last_run;
   logic [W-1:0]          mask_xor;
   logic [W-1:0]          out_xor;
   logic [(D+1)*W-1:0]    shares;
`ifdef MKH_KAT_CHECK_EN
   logic [W-1:0]          exp_q;
`endif

   mkh_xor_reduce #(.N(D), .W(W)) u_mask_xor (
      .words  (MaskRand),
      .result (mask_xor)
   );

   mkh_xor_reduce #(.N(D + 1), .W(W)) u_unmask (
      .words  (CoreOut),
      .result (out_xor)
   );

   // Top share carries the data; lower shares are the raw masks.
   assign shares      = {in_q ^ mask_xor, MaskRand};
   assign ready_edge  = CoreReady & ~ready_q;
   assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT));
   assign last_run    = (({1'b0, RunCount} + 1'b1) >= {1'b0, runs_q});

   assign Busy      = (state != IDLE);
   assign Done      = (state == DONE);
   assign CoreReset = (state != WAIT);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (Start) state_next = SHARE;
         SHARE:   state_next = LAUNCH;
         LAUNCH:  state_next = WAIT;
         WAIT: begin
            if (ready_edge)       state_next = UNMASK;
            else if (cnt_expired) state_next = DONE;
         end
         UNMASK:  state_next = last_run ? DONE : SHARE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         in_q     <= '0;
         result_q <= '0;
         runs_q   <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         OutData  <= '0;
         Mismatch <= 1'b0;
         Timeout  <= 1'b0;
         RunCount <= '0;
         CoreIn   <= '0;
`ifdef MKH_KAT_CHECK_EN
         exp_q    <= '0;
         Pass     <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         ready_q <= CoreReady;
         unique case (state)
            IDLE: begin
               if (Start) begin
                  in_q     <= InData;
                  runs_q   <= (Runs == '0) ? RUN_W'(1) : Runs;
                  Mismatch <= 1'b0;
                  Timeout  <= 1'b0;
                  RunCount <= '0;
`ifdef MKH_KAT_CHECK_EN
                  exp_q    <= ExpData;
`endif
               end
            end
            SHARE:  CoreIn <= shares;
            LAUNCH: cnt_q  <= '0;
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // A Ready edge in the final counted cycle still counts as success.
               if (ready_edge)       result_q <= out_xor;
               else if (cnt_expired) Timeout  <= 1'b1;
            end
            UNMASK: begin
               RunCount <= RunCount + 1'b1;
               if (RunCount == '0)          OutData  <= result_q;
               else if (result_q != OutData) Mismatch <= 1'b1;
            end
            DONE: begin
`ifdef MKH_KAT_CHECK_EN
               Pass <= (OutData == exp_q) & ~Mismatch & ~Timeout;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_masked_keccak_harness.sv
// Self-checking bench for masked_keccak_harness with a behavioural stub core.
// Define MKH_KAT_CHECK_EN for both files to exercise the known-answer compare.
module tb_masked_keccak_harness;

   localparam int D       = 1;
   localparam int W       = 200;
   localparam int RUN_W   = 4;
   localparam int TIMEOUT = 64;
   localparam int BUDGET  = 3000;
   localparam logic [W-1:0] KCONST = 200'h5a3c96e10f87d2b4c1e93a7f06b5d8241c9e7a3f5b0d86e2c4;

   typedef struct {
      logic [W-1:0] out;
      logic         mis;
      logic         to;
      int           rc;
      int           n;
   } exp_t;

   logic                 Clock = 1'b0;
   logic                 Reset = 1'b1;
   logic                 Start = 1'b0;
   logic [RUN_W-1:0]     Runs = '0;
   logic [W-1:0]         InData = '0;
   logic [D*W-1:0]       MaskRand = '0;
   logic                 Busy, Done, Mismatch, Timeout, CoreReset;
   logic [W-1:0]         OutData;
   logic [RUN_W-1:0]     RunCount;
   logic [(D+1)*W-1:0]   CoreIn;
   logic                 CoreReady = 1'b0;
   logic [(D+1)*W-1:0]   CoreOut = '0;
`ifdef MKH_KAT_CHECK_EN
   logic [W-1:0]         ExpData = '0;
   logic                 Pass;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];

   // Stub core controls
   int                   stub_lat = 0;
   int                   stub_mode = 0;     // 0 normal, 1 never ready, 2 ready held high
   bit                   stub_corrupt = 1'b0;
   int                   stub_base = 0;
   int                   core_runs = 0;
   int                   core_cnt = 0;
   logic [W-1:0]         stub_m, stub_r;

   logic [W-1:0]         model_out = '0;
   logic [W-1:0]         cur_in = '0;
   logic [(D+1)*W-1:0]   prev_core_in = '0;
   int                   run_in_cmd = 0;
   logic                 prev_cr = 1'b1;

   masked_keccak_harness #(.D(D), .W(W), .RUN_W(RUN_W), .TIMEOUT(TIMEOUT)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Runs      (Runs),
      .InData    (InData),
      .MaskRand  (MaskRand),
      .Busy      (Busy),
      .Done      (Done),
      .OutData   (OutData),
      .Mismatch  (Mismatch),
      .Timeout   (Timeout),
      .RunCount  (RunCount),
      .CoreReset (CoreReset),
      .CoreIn    (CoreIn),
      .CoreReady (CoreReady),
      .CoreOut   (CoreOut)
`ifdef MKH_KAT_CHECK_EN
      ,
      .ExpData   (ExpData),
      .Pass      (Pass)
`endif
   );

   always #5 Clock = ~Clock;

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom);
      return r;
   endfunction

   function automatic logic [W-1:0] core_fn(input logic [W-1:0] x);
      return {x[W-9:0], x[W-1:W-8]} ^ KCONST;
   endfunction

   function automatic logic [W-1:0] unmask(input logic [(D+1)*W-1:0] s);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i <= D; i++) r ^= s[i*W +: W];
      return r;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge Clock) MaskRand = rand_word();

   // Stub core: after stub_lat cycles out of reset, present fresh shares of core_fn.
   always @(posedge Clock) begin
      if (CoreReset) begin
         core_cnt  <= 0;
         CoreReady <= (stub_mode == 2);
      end else begin
         core_cnt <= core_cnt + 1;
         if (stub_mode == 0 && core_cnt == stub_lat) begin
            stub_m = rand_word();
            stub_r = core_fn(unmask(CoreIn));
            if (stub_corrupt && (core_runs - stub_base) == 1) stub_r[0] = ~stub_r[0];
            CoreOut   <= {stub_r ^ stub_m, stub_m};
            CoreReady <= 1'b1;
            core_runs <= core_runs + 1;
         end
      end
   end

   // Each launch: shares recombine to the command input and masks are fresh.
   always @(negedge Clock) begin
      if (prev_cr && !CoreReset) begin
         check("share_xor", unmask(CoreIn), cur_in);
         if (run_in_cmd > 0) check("share_fresh", W'(CoreIn != prev_core_in), W'(1));
         prev_core_in = CoreIn;
         run_in_cmd++;
      end
      prev_cr = CoreReset;
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},     Busy, 0);
      check({tag, "_done"},     Done, 0);
      check({tag, "_outdata"},  OutData, 0);
      check({tag, "_mismatch"}, Mismatch, 0);
      check({tag, "_timeout"},  Timeout, 0);
      check({tag, "_runcount"}, RunCount, 0);
      check({tag, "_corereset"}, CoreReset, 1);
      check({tag, "_corein"},   CoreIn[W-1:0] | CoreIn[2*W-1:W], 0);
   endtask

   task automatic run_cmd(input string tag, input logic [W-1:0] data, input int runs,
                          input int lat, input int mode, input bit corrupt, input int hold_start);
      exp_t e;
      exp_t got_e;
      int   eff;
      int   n;
      bit   timed;
      eff   = (runs == 0) ? 1 : runs;
      timed = (mode != 0) || (lat + 2 > TIMEOUT + 1);
      if (timed) begin
         e.out = model_out; e.mis = 1'b0; e.to = 1'b1; e.rc = 0; e.n = TIMEOUT + 3;
      end else begin
         e.out = core_fn(data); e.mis = corrupt && (eff >= 2); e.to = 1'b0;
         e.rc = eff; e.n = eff * (lat + 5);
         model_out = e.out;
      end
      exp_q.push_back(e);
      stub_lat = lat; stub_mode = mode; stub_corrupt = corrupt; stub_base = core_runs;
      cur_in = data; run_in_cmd = 0;

      @(negedge Clock);
      InData = data; Runs = RUN_W'(runs); Start = 1'b1;
      @(negedge Clock);
      n = 0;
      while (n < BUDGET) begin
         if (Done) break;
         if (n >= hold_start) Start = 1'b0;
         @(negedge Clock);
         n++;
      end
      Start = 1'b0;
      got_e = exp_q.pop_front();
      if (n >= BUDGET) begin
         check({tag, "_done_wait"}, Done, 1);
      end else begin
         check({tag, "_latency"},   n, got_e.n);
         check({tag, "_outdata"},   OutData, got_e.out);
         check({tag, "_mismatch"},  Mismatch, got_e.mis);
         check({tag, "_timeout"},   Timeout, got_e.to);
         check({tag, "_runcount"},  RunCount, got_e.rc);
         check({tag, "_busy_done"}, Busy, 1);
         check({tag, "_corereset"}, CoreReset, 1);
         @(negedge Clock);
         check({tag, "_done_pulse"}, Done, 0);
         check({tag, "_busy_idle"},  Busy, 0);
      end
   endtask

   initial begin
      logic [W-1:0] vec;
      int done_seen;
      vec = {128'hffffffffffffffffffffffffffffffff, 72'h0123456789abcdef01};

      repeat (3) @(negedge Clock);
      check_reset_values("rst");
      Reset = 1'b0;
      @(negedge Clock);
      check_reset_values("idle");

      run_cmd("single",   vec, 1, 5, 0, 1'b0, 0);
      run_cmd("triple",   vec, 3, 2, 0, 1'b0, 0);
      run_cmd("corrupt",  vec ^ W'(200'h55), 2, 4, 0, 1'b1, 0);
      run_cmd("never",    vec, 1, 0, 1, 1'b0, 0);
      run_cmd("edge_wins", vec, 1, TIMEOUT - 1, 0, 1'b0, 0);
      run_cmd("edge_late", vec ^ W'(1), 1, TIMEOUT, 0, 1'b0, 0);
      run_cmd("held_high", vec, 1, 0, 2, 1'b0, 0);
      run_cmd("start_held", vec ^ KCONST, 1, 3, 0, 1'b0, 3);

      // Reset in the middle of WAIT must abort without a Done pulse.
      stub_lat = 20; stub_mode = 0; stub_corrupt = 1'b0;
      cur_in = rand_word(); run_in_cmd = 0;
      @(negedge Clock);
      InData = cur_in; Runs = RUN_W'(2); Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (4) @(negedge Clock);
      check("mid_busy", Busy, 1);
      check("mid_corereset", CoreReset, 0);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check_reset_values("midrst");
      model_out = '0;
      done_seen = 0;
      repeat (40) begin
         @(negedge Clock);
         if (Done) done_seen++;
      end
      check("midrst_no_done", done_seen, 0);

      run_cmd("runs_zero", rand_word(), 0, 1, 0, 1'b0, 0);

      for (int i = 0; i < 4; i++) begin
         run_cmd("rand", rand_word(), $urandom_range(1, 4), $urandom_range(0, 10), 0, 1'b0, 0);
      end

`ifdef MKH_KAT_CHECK_EN
      ExpData = core_fn(vec) ^ W'(1);
      run_cmd("kat_bad", vec, 1, 2, 0, 1'b0, 0);
      check("kat_bad_pass", Pass, 0);
      ExpData = core_fn(vec);
      run_cmd("kat_good", vec, 2, 2, 0, 1'b0, 0);
      check("kat_good_pass", Pass, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
